reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares main_module's single register-bus slave port between two masters: requester 0 is the Wishbone adapter; requester 1 is the UART command engine.
- Round-robin arbitration; a transaction holds the bus from grant until completion.
- A per-transaction timeout guarantees every accepted request is answered, even if the target never acks.
- Sits between the user_proj_example glue and main_module's valid/wstrb/wdata/addr/we/ready/rdata port.

Parameters:
- WORD_SIZE, 32, data width of wdata/rdata.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 256, BUSY cycles without s_ready_i before forced completion; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_valid_i  in  1  requester 0 request; held until m0_ready_o.
- m0_we_i  in  1  write enable (1 = write).
- m0_wstrb_i  in  4  byte strobes.
- m0_addr_i  in  ADDR_WIDTH  address.
- m0_wdata_i  in  WORD_SIZE  write data.
- m0_ready_o  out  1  one-cycle completion pulse.
- m0_rdata_o  out  WORD_SIZE  read data, valid while m0_ready_o=1.
- m0_err_o  out  1  pulses with m0_ready_o on timeout.
- m1_*  (same set as m0_*)  requester 1.
- s_valid_o  out  1  target request.
- s_we_o  out  1  target write enable.
- s_wstrb_o  out  4  target byte strobes.
- s_addr_o  out  ADDR_WIDTH  target address.
- s_wdata_o  out  WORD_SIZE  target write data.
- s_ready_i  in  1  target completion.
- s_rdata_i  in  WORD_SIZE  target read data, sampled when s_ready_i=1.
- grant_o  out  2  one-hot owner of the bus; 00 in IDLE.
- busy_o  out  1  1 in BUSY or DONE.

Behaviour:
- Reset (rst=0, async): state=IDLE; last_grant=1, so requester 0 wins the first tie. All outputs 0, including every s_* output, grant_o, ready/err pulses, and rdata registers. Any in-flight transaction is dropped and no ready is issued for it.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one mN_valid_i=1, grant N.
  - If both are 1, grant the requester != last_grant.
  - On grant: register we/wstrb/addr/wdata into the s_* registers, set grant_o, clear timeout count, set last_grant=N, go to BUSY.
- BUSY:
  - s_valid_o=1; s_* fields stay stable for the whole BUSY period.
  - s_ready_i=1: capture s_rdata_i into mN_rdata_o, err=0, go to DONE.
  - Else, count+1. If TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES-1: rdata=TIMEOUT_DATA, err=1, go to DONE.
  - s_ready_i and timeout in the same cycle: s_ready_i wins, err=0.
- DONE:
  - s_valid_o=0; mN_ready_o=1 for exactly one cycle, with mN_err_o=err.
  - Next state is IDLE; grant_o cleared on entering IDLE.
- Latency:
  - Valid seen in cycle N gives s_valid_o in N+1.
  - s_ready_i in cycle M gives mN_ready_o in M+1.
  - Minimum valid-to-ready is 2 cycles.
- Back-to-back: a requester may reassert valid in the cycle after its ready; it is arbitrated normally in IDLE.
- No combinational path from any input to any output; all outputs are registered.
- Requester drops valid mid-BUSY (protocol violation): transaction still completes and the ready pulse is still issued.
- The non-granted requester's ready/err/rdata stay 0. Its request is held pending and served next under round-robin.
- Writes: s_rdata_i is still captured into rdata; masters ignore it.
- Timeout counter width is clog2(TIMEOUT_CYCLES)+1. It saturates and cannot wrap.

Decomposition:
- Package reg_bus_arbiter_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - GRANT_NONE/GRANT_M0/GRANT_M1 constants;
  - default TIMEOUT_DATA.
- One sub-module, rr_arb2: inputs req[1:0] and last_grant; output one-hot grant. Purely combinational, reused by future multi-master blocks.
- FSM, capture registers and timeout counter live in the top.

Test Plan:
- Single write, m0 addr=0x3000_0004 wdata=0x0000_00A5 wstrb=0xF, target acks 1 cycle after s_valid_o -> s_* match the request; m0_ready_o pulses at cycle N+3 with m0_err_o=0; m1 outputs stay 0.
- Simultaneous m0 and m1 reads, both held asserted -> order m0, m1, m0, m1 (first tie goes to m0); grant_o toggles 01/10; each completion returns its own s_rdata_i (0x1111_1111 / 0x2222_2222).
- Target never acks, TIMEOUT_CYCLES=8 -> forced completion after 8 BUSY cycles; m1_rdata_o=0xDEAD_BEEF and m1_err_o=1 for one cycle; then IDLE.
- s_ready_i rises in the same cycle the timeout count expires -> normal completion: rdata = s_rdata_i, err=0.
- rst pulled low mid-BUSY -> s_valid_o, grant_o and busy_o go 0 immediately (async); no ready pulse. After release, a pending m1 request is granted first if m0 is idle, and the first tie goes to m0.
- m0 drops valid during BUSY -> target transaction still completes and m0_ready_o pulses once; the following IDLE accepts m1.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
package reg_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, ties go to the requester that
// did not win last time (last_grant = 1 means requester 1 won last).
module rr_arb2
    import reg_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = GRANT_NONE;
        if (req == 2'b11) begin
            grant = last_grant ? GRANT_M0 : GRANT_M1;
        end else if (req[0]) begin
            grant = GRANT_M0;
        end else if (req[1]) begin
            grant = GRANT_M1;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-bus target between two masters with round-robin
// arbitration and a per-transaction timeout that forces an error completion.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int                   WORD_SIZE      = 32,
    parameter int                   ADDR_WIDTH     = 32,
    parameter int                   TIMEOUT_CYCLES = 256,
    parameter logic [WORD_SIZE-1:0] TIMEOUT_DATA   = WORD_SIZE'(DEFAULT_TIMEOUT_DATA)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_wstrb_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WORD_SIZE-1:0]  m0_wdata_i,
    output logic                  m0_ready_o,
    output logic [WORD_SIZE-1:0]  m0_rdata_o,
    output logic                  m0_err_o,

    input  logic                  m1_valid_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_wstrb_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WORD_SIZE-1:0]  m1_wdata_i,
    output logic                  m1_ready_o,
    output logic [WORD_SIZE-1:0]  m1_rdata_o,
    output logic                  m1_err_o,

    output logic                  s_valid_o,
    output logic                  s_we_o,
    output logic [3:0]            s_wstrb_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [WORD_SIZE-1:0]  s_wdata_o,
    input  logic                  s_ready_i,
    input  logic [WORD_SIZE-1:0]  s_rdata_i,

    output logic [1:0]            grant_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic [1:0]       arb_grant;
    logic [CNT_W-1:0] count;
    logic             start;
    logic             finish;
    logic             timed_out;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_valid_i, m0_valid_i}),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A target ack in the same cycle as the timeout expiry takes priority.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_grant != GRANT_NONE) begin
                    start      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (s_ready_i) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end else if (TIMEOUT_EN && (count == CNT_LAST)) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            grant_o    <= GRANT_NONE;
            count      <= '0;
            s_valid_o  <= 1'b0;
            s_we_o     <= 1'b0;
            s_wstrb_o  <= '0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            m0_ready_o <= 1'b0;
            m0_err_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_ready_o <= 1'b0;
            m1_err_o   <= 1'b0;
            m1_rdata_o <= '0;
        end else begin
            if (start) begin
                grant_o    <= arb_grant;
                last_grant <= arb_grant[1];
                count      <= '0;
                s_valid_o  <= 1'b1;
                if (arb_grant[1]) begin
                    s_we_o    <= m1_we_i;
                    s_wstrb_o <= m1_wstrb_i;
                    s_addr_o  <= m1_addr_i;
                    s_wdata_o <= m1_wdata_i;
                end else begin
                    s_we_o    <= m0_we_i;
                    s_wstrb_o <= m0_wstrb_i;
                    s_addr_o  <= m0_addr_i;
                    s_wdata_o <= m0_wdata_i;
                end
            end

            if ((state == BUSY) && !finish && (count != '1)) begin
                count <= count + 1'b1;
            end

            if (finish) begin
                s_valid_o  <= 1'b0;
                m0_ready_o <= grant_o[0];
                m1_ready_o <= grant_o[1];
                m0_err_o   <= grant_o[0] & timed_out;
                m1_err_o   <= grant_o[1] & timed_out;
                if (grant_o[0]) begin
                    m0_rdata_o <= timed_out ? TIMEOUT_DATA : s_rdata_i;
                end
                if (grant_o[1]) begin
                    m1_rdata_o <= timed_out ? TIMEOUT_DATA : s_rdata_i;
                end
            end

            if (state == DONE) begin
                grant_o    <= GRANT_NONE;
                m0_ready_o <= 1'b0;
                m0_err_o   <= 1'b0;
                m0_rdata_o <= '0;
                m1_ready_o <= 1'b0;
                m1_err_o   <= 1'b0;
                m1_rdata_o <= '0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed scenario bench for reg_bus_arbiter; inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_reg_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_valid_i, m0_we_i, m0_ready_o, m0_err_o;
    logic [3:0]  m0_wstrb_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_valid_i, m1_we_i, m1_ready_o, m1_err_o;
    logic [3:0]  m1_wstrb_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic        s_valid_o, s_we_o, s_ready_i;
    logic [3:0]  s_wstrb_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    int total;
    int bad;

    reg_bus_arbiter #(
        .WORD_SIZE      (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid_i (m0_valid_i),
        .m0_we_i    (m0_we_i),
        .m0_wstrb_i (m0_wstrb_i),
        .m0_addr_i  (m0_addr_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_ready_o (m0_ready_o),
        .m0_rdata_o (m0_rdata_o),
        .m0_err_o   (m0_err_o),
        .m1_valid_i (m1_valid_i),
        .m1_we_i    (m1_we_i),
        .m1_wstrb_i (m1_wstrb_i),
        .m1_addr_i  (m1_addr_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_ready_o (m1_ready_o),
        .m1_rdata_o (m1_rdata_o),
        .m1_err_o   (m1_err_o),
        .s_valid_o  (s_valid_o),
        .s_we_o     (s_we_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_ready_i  (s_ready_i),
        .s_rdata_i  (s_rdata_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_valid_i = 1'b0; m0_we_i = 1'b0; m0_wstrb_i = 4'h0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_valid_i = 1'b0; m1_we_i = 1'b0; m1_wstrb_i = 4'h0; m1_addr_i = '0; m1_wdata_i = '0;
        s_ready_i  = 1'b0; s_rdata_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++;
        if ({s_valid_o, s_we_o, s_wstrb_o, grant_o, busy_o, m0_ready_o, m0_err_o, m1_ready_o, m1_err_o} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b required 0",
                     {s_valid_o, s_we_o, s_wstrb_o, grant_o, busy_o, m0_ready_o, m0_err_o, m1_ready_o, m1_err_o});
        end
        total++;
        if ({s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h required 0", {s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        m0_we_i = 1'b1; m0_wstrb_i = 4'hF; m0_addr_i = 32'h3000_0004; m0_wdata_i = 32'h0000_00A5;
        m0_valid_i = 1'b1;
        @(negedge clk);
        total++;
        if ({s_valid_o, s_we_o, s_wstrb_o, s_addr_o, s_wdata_o} !== {1'b1, 1'b1, 4'hF, 32'h3000_0004, 32'h0000_00A5}) begin
            bad++;
            $display("[TB] FAIL write_fields: got v=%b we=%b st=%h a=%h d=%h required 1 1 f 30000004 000000a5",
                     s_valid_o, s_we_o, s_wstrb_o, s_addr_o, s_wdata_o);
        end
        total++;
        if ({grant_o, busy_o, m0_ready_o} !== 4'b0110) begin
            bad++;
            $display("[TB] FAIL write_grant: got g=%b busy=%b rdy=%b required 01 1 0", grant_o, busy_o, m0_ready_o);
        end
        @(negedge clk);
        s_ready_i = 1'b1;
        s_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        s_ready_i = 1'b0;
        total++;
        if ({m0_ready_o, m0_err_o, m1_ready_o, m1_err_o, s_valid_o} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL write_done: got m0r=%b m0e=%b m1r=%b m1e=%b sv=%b required 1 0 0 0 0",
                     m0_ready_o, m0_err_o, m1_ready_o, m1_err_o, s_valid_o);
        end
        total++;
        if ({m0_rdata_o, m1_rdata_o} !== {32'hCAFE_0001, 32'h0}) begin
            bad++;
            $display("[TB] FAIL write_rdata: got m0=%h m1=%h required cafe0001 0", m0_rdata_o, m1_rdata_o);
        end
        m0_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({m0_ready_o, grant_o, busy_o} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL write_idle: got rdy=%b g=%b busy=%b required 0 00 0", m0_ready_o, grant_o, busy_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_order [4];
        logic [31:0] exp_data;
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m0_we_i = 1'b0; m0_addr_i = 32'h0000_0010;
        m1_we_i = 1'b0; m1_addr_i = 32'h0000_0020;
        m0_valid_i = 1'b1;
        m1_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!s_valid_o && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            total++;
            if (s_valid_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rr_wait[%0d]: got s_valid=%b required 1 within 10 cycles", i, s_valid_o);
            end
            total++;
            if (grant_o !== exp_order[i]) begin
                bad++;
                $display("[TB] FAIL rr_grant[%0d]: got %b required %b", i, grant_o, exp_order[i]);
            end
            s_ready_i = 1'b1;
            s_rdata_i = (s_addr_o == 32'h0000_0010) ? 32'h1111_1111 : 32'h2222_2222;
            @(negedge clk);
            s_ready_i = 1'b0;
            exp_data = exp_order[i][0] ? 32'h1111_1111 : 32'h2222_2222;
            total++;
            if ({m1_ready_o, m0_ready_o} !== exp_order[i]) begin
                bad++;
                $display("[TB] FAIL rr_ready[%0d]: got %b required %b", i, {m1_ready_o, m0_ready_o}, exp_order[i]);
            end
            total++;
            if ((exp_order[i][0] ? {m0_rdata_o, m1_rdata_o} : {m1_rdata_o, m0_rdata_o}) !== {exp_data, 32'h0}) begin
                bad++;
                $display("[TB] FAIL rr_rdata[%0d]: got m0=%h m1=%h required owner=%h other=0", i, m0_rdata_o, m1_rdata_o, exp_data);
            end
            if (i == 3) begin
                m0_valid_i = 1'b0;
                m1_valid_i = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        m1_we_i = 1'b0; m1_addr_i = 32'h0000_0040;
        m1_valid_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({s_valid_o, m1_ready_o, busy_o} !== 3'b101) begin
                bad++;
                $display("[TB] FAIL to_busy[%0d]: got sv=%b rdy=%b busy=%b required 1 0 1", k, s_valid_o, m1_ready_o, busy_o);
            end
        end
        @(negedge clk);
        total++;
        if ({m1_ready_o, m1_err_o, m0_ready_o, s_valid_o} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL to_done: got m1r=%b m1e=%b m0r=%b sv=%b required 1 1 0 0", m1_ready_o, m1_err_o, m0_ready_o, s_valid_o);
        end
        total++;
        if (m1_rdata_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL to_rdata: got %h required deadbeef", m1_rdata_o);
        end
        m1_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({m1_ready_o, m1_err_o, busy_o, grant_o} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL to_idle: got rdy=%b err=%b busy=%b g=%b required 0 0 0 00", m1_ready_o, m1_err_o, busy_o, grant_o);
        end
    endtask

    task automatic test_ready_at_timeout();
        m0_we_i = 1'b0; m0_addr_i = 32'h0000_0050;
        m0_valid_i = 1'b1;
        repeat (8) @(negedge clk);
        s_ready_i = 1'b1;
        s_rdata_i = 32'h5A5A_5A5A;
        @(negedge clk);
        s_ready_i = 1'b0;
        total++;
        if ({m0_ready_o, m0_err_o} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL race_flags: got rdy=%b err=%b required 1 0", m0_ready_o, m0_err_o);
        end
        total++;
        if (m0_rdata_o !== 32'h5A5A_5A5A) begin
            bad++;
            $display("[TB] FAIL race_rdata: got %h required 5a5a5a5a", m0_rdata_o);
        end
        m0_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        m0_we_i = 1'b0; m0_addr_i = 32'h0000_0060;
        m0_valid_i = 1'b1;
        @(negedge clk);
        total++;
        if (s_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_busy: got s_valid=%b required 1", s_valid_o);
        end
        m1_we_i = 1'b0; m1_addr_i = 32'h0000_0070;
        m1_valid_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({s_valid_o, grant_o, busy_o} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL async_rst: got sv=%b g=%b busy=%b required 0 00 0", s_valid_o, grant_o, busy_o);
        end
        m0_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({m0_ready_o, m1_ready_o} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rst_noready: got m0r=%b m1r=%b required 0 0", m0_ready_o, m1_ready_o);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({grant_o, s_addr_o, m0_ready_o} !== {2'b10, 32'h0000_0070, 1'b0}) begin
            bad++;
            $display("[TB] FAIL post_rst_grant: got g=%b a=%h m0r=%b required 10 00000070 0", grant_o, s_addr_o, m0_ready_o);
        end
        s_ready_i = 1'b1;
        s_rdata_i = 32'h7777_0000;
        @(negedge clk);
        s_ready_i = 1'b0;
        total++;
        if ({m1_ready_o, m0_ready_o, m1_rdata_o} !== {2'b10, 32'h7777_0000}) begin
            bad++;
            $display("[TB] FAIL post_rst_done: got m1r=%b m0r=%b d=%h required 1 0 77770000", m1_ready_o, m0_ready_o, m1_rdata_o);
        end
        m1_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_valid();
        m0_we_i = 1'b1; m0_wstrb_i = 4'h3; m0_addr_i = 32'h0000_0080; m0_wdata_i = 32'h1234_5678;
        m0_valid_i = 1'b1;
        @(negedge clk);
        total++;
        if ({s_valid_o, grant_o} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL drop_start: got sv=%b g=%b required 1 01", s_valid_o, grant_o);
        end
        m0_valid_i = 1'b0;
        m1_we_i = 1'b0; m1_addr_i = 32'h0000_0090;
        m1_valid_i = 1'b1;
        s_ready_i = 1'b1;
        s_rdata_i = 32'h0000_0009;
        @(negedge clk);
        s_ready_i = 1'b0;
        total++;
        if ({m0_ready_o, m1_ready_o} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL drop_done: got m0r=%b m1r=%b required 1 0", m0_ready_o, m1_ready_o);
        end
        @(negedge clk);
        total++;
        if ({m0_ready_o, grant_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL drop_once: got m0r=%b g=%b required 0 00", m0_ready_o, grant_o);
        end
        @(negedge clk);
        total++;
        if ({grant_o, s_addr_o} !== {2'b10, 32'h0000_0090}) begin
            bad++;
            $display("[TB] FAIL drop_next: got g=%b a=%h required 10 00000090", grant_o, s_addr_o);
        end
        s_ready_i = 1'b1;
        s_rdata_i = 32'hABCD_0123;
        @(negedge clk);
        s_ready_i = 1'b0;
        total++;
        if ({m1_ready_o, m1_rdata_o} !== {1'b1, 32'hABCD_0123}) begin
            bad++;
            $display("[TB] FAIL drop_m1: got r=%b d=%h required 1 abcd0123", m1_ready_o, m1_rdata_o);
        end
        m1_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_busy();
        test_drop_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
